pwm_ramp_ctrl: RTL

PWM_RAMP_CTRL -- requirements
Module: pwm_ramp_ctrl

---
 rtl/pwm_ramp_ctrl.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/pwm_ramp_ctrl.sv
// pwm_ramp_ctrl: walks a PWM duty value toward a commanded target in fixed
// increments, one increment every cmd_hold PWM periods, with abort support.
// Duty spans 0..2^R, so duty and target carry R+1 bits.
module pwm_ramp_ctrl #(
  parameter int R         = 8,
  parameter int HOLD_BITS = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [R:0]           cmd_target,
  input  logic [R-1:0]         cmd_step,
  input  logic [HOLD_BITS-1:0] cmd_hold,
  input  logic                 period_tick,
  input  logic                 abort,
  output logic [R:0]           duty,
  output logic                 busy,
  output logic                 done,
  output logic                 aborted
);

  typedef enum logic {IDLE, RAMP} state_t;

  localparam logic [R:0] DUTY_MAX = {1'b1, {R{1'b0}}};

  state_t               state_q, state_d;
  logic [R:0]           duty_q, duty_d;
  logic [R:0]           target_q, target_d;
  logic [R-1:0]         step_q, step_d;
  logic [HOLD_BITS-1:0] hold_q, hold_d;
  logic [HOLD_BITS-1:0] cnt_q, cnt_d;
  logic                 done_q, done_d;
  logic                 aborted_q, aborted_d;

  // Command normalisation: clamp target, zero step/hold behave as one.
  logic [R:0]           tgt_clamped;
  logic [R-1:0]         step_norm;
  logic [HOLD_BITS-1:0] hold_norm;
  logic [R:0]           step_ext;
  logic [R:0]           up_gap;
  logic [R:0]           down_gap;
  logic [R:0]           stepped;
  logic                 accept;

  assign tgt_clamped = (cmd_target > DUTY_MAX) ? DUTY_MAX : cmd_target;
  assign step_norm   = (cmd_step == '0) ? R'(1) : cmd_step;
  assign hold_norm   = (cmd_hold == '0) ? HOLD_BITS'(1) : cmd_hold;

  // Gaps are only used in the direction where they cannot go negative, so a
  // saturating compare against the step never overshoots or wraps.
  assign step_ext = {1'b0, step_q};
  assign up_gap   = target_q - duty_q;
  assign down_gap = duty_q - target_q;

  // Candidate next duty for one step toward the latched target.
  always_comb begin
    stepped = target_q;
    if (target_q > duty_q) begin
      stepped = (up_gap <= step_ext) ? target_q : (duty_q + step_ext);
    end else if (target_q < duty_q) begin
      stepped = (down_gap <= step_ext) ? target_q : (duty_q - step_ext);
    end
  end

  assign cmd_ready = (state_q == IDLE) && !reset;
  assign accept    = cmd_valid && cmd_ready;

  // Next-state logic: command acceptance, period counting, stepping, abort.
  always_comb begin
    state_d   = state_q;
    duty_d    = duty_q;
    target_d  = target_q;
    step_d    = step_q;
    hold_d    = hold_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    aborted_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          target_d = tgt_clamped;
          step_d   = step_norm;
          hold_d   = hold_norm;
          cnt_d    = '0;
          if (tgt_clamped == duty_q) begin
            done_d = 1'b1;
          end else begin
            state_d = RAMP;
          end
        end
      end
      RAMP: begin
        if (abort) begin
          // Abort beats a coincident tick: duty is frozen where it is.
          state_d   = IDLE;
          aborted_d = 1'b1;
        end else if (period_tick) begin
          if (cnt_q == hold_q - HOLD_BITS'(1)) begin
            cnt_d  = '0;
            duty_d = stepped;
            if (stepped == target_q) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + HOLD_BITS'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register with synchronous reset overriding every other input.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      duty_q    <= '0;
      target_q  <= '0;
      step_q    <= '0;
      hold_q    <= '0;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      duty_q    <= duty_d;
      target_q  <= target_d;
      step_q    <= step_d;
      hold_q    <= hold_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
    end
  end

  assign duty    = duty_q;
  assign busy    = (state_q == RAMP);
  assign done    = done_q;
  assign aborted = aborted_q;

endmodule
